// File: rtl/ping_sequencer.sv
// ping_sequencer: one sonar ping per accepted start request.
// A ping is a square-wave burst (n_cycles x {POS half, NEG half}) encoded as
// h_bridge hstate codes, then an optional dead time, then an optional listen window.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   start, abort        ping request / immediate termination
//   half_period         clk cycles per excitation half (>= 2)
//   n_cycles            full excitation cycles per burst (>= 1)
//   dead_time           ring-down cycles between burst and listen (0 = skip)
//   listen_len          listen window length in clk cycles (0 = skip)
//   hstate              h_bridge command (OFF / POS / NEG)
//   txrx                1 = receiver isolated, 0 = receiving
//   busy                high from the first TX cycle through the last listen cycle
//   listen, listen_idx  listen window flag and 0-based cycle index
//   done, err           completion pulse / rejected-start pulse
module ping_sequencer #(
  parameter int unsigned HP_W = 16,
  parameter int unsigned NC_W = 8,
  parameter int unsigned LW_W = 24
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [HP_W-1:0] half_period,
  input  logic [NC_W-1:0] n_cycles,
  input  logic [HP_W-1:0] dead_time,
  input  logic [LW_W-1:0] listen_len,
  output logic [1:0]      hstate,
  output logic            txrx,
  output logic            busy,
  output logic            listen,
  output logic [LW_W-1:0] listen_idx,
  output logic            done,
  output logic            err
);

  // h_bridge command encoding
  localparam logic [1:0] HB_OFF = 2'b00;
  localparam logic [1:0] HB_POS = 2'b01;
  localparam logic [1:0] HB_NEG = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX_POS,
    S_TX_NEG,
    S_DEAD,
    S_LISTEN
  } state_t;

  state_t          state_q;
  logic [HP_W-1:0] hp_q, dt_q, cnt_q;
  logic [NC_W-1:0] nc_q, cyc_q;
  logic [LW_W-1:0] ll_q, idx_q;
  logic [1:0]      hstate_q;
  logic            txrx_q, busy_q, listen_q, done_q, err_q;

  // Sequencer: state, latched config, counters and registered outputs together
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      hp_q     <= '0;
      nc_q     <= '0;
      dt_q     <= '0;
      ll_q     <= '0;
      cnt_q    <= '0;
      cyc_q    <= '0;
      idx_q    <= '0;
      hstate_q <= HB_OFF;
      txrx_q   <= 1'b1;
      busy_q   <= 1'b0;
      listen_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (state_q != S_IDLE && abort) begin
        // Abort always lands on OFF, so POS/NEG never abut across an abort
        state_q  <= S_IDLE;
        cnt_q    <= '0;
        cyc_q    <= '0;
        idx_q    <= '0;
        hstate_q <= HB_OFF;
        txrx_q   <= 1'b1;
        busy_q   <= 1'b0;
        listen_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start && !abort) begin
              if (half_period < HP_W'(2) || n_cycles == '0) begin
                err_q <= 1'b1;
              end else begin
                hp_q     <= half_period;
                nc_q     <= n_cycles;
                dt_q     <= dead_time;
                ll_q     <= listen_len;
                cnt_q    <= '0;
                cyc_q    <= '0;
                state_q  <= S_TX_POS;
                hstate_q <= HB_POS;
                busy_q   <= 1'b1;
              end
            end
          end
          S_TX_POS: begin
            if (cnt_q == hp_q - HP_W'(1)) begin
              cnt_q    <= '0;
              state_q  <= S_TX_NEG;
              hstate_q <= HB_NEG;
            end else begin
              cnt_q <= cnt_q + HP_W'(1);
            end
          end
          S_TX_NEG: begin
            if (cnt_q != hp_q - HP_W'(1)) begin
              cnt_q <= cnt_q + HP_W'(1);
            end else if (cyc_q != nc_q - NC_W'(1)) begin
              cnt_q    <= '0;
              cyc_q    <= cyc_q + NC_W'(1);
              state_q  <= S_TX_POS;
              hstate_q <= HB_POS;
            end else begin
              // Burst finished: fall through to DEAD, LISTEN or completion
              cnt_q    <= '0;
              cyc_q    <= '0;
              hstate_q <= HB_OFF;
              if (dt_q != '0) begin
                state_q <= S_DEAD;
              end else if (ll_q != '0) begin
                state_q  <= S_LISTEN;
                txrx_q   <= 1'b0;
                listen_q <= 1'b1;
                idx_q    <= '0;
              end else begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
          S_DEAD: begin
            if (cnt_q != dt_q - HP_W'(1)) begin
              cnt_q <= cnt_q + HP_W'(1);
            end else begin
              cnt_q <= '0;
              if (ll_q != '0) begin
                state_q  <= S_LISTEN;
                txrx_q   <= 1'b0;
                listen_q <= 1'b1;
                idx_q    <= '0;
              end else begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
          S_LISTEN: begin
            if (idx_q != ll_q - LW_W'(1)) begin
              idx_q <= idx_q + LW_W'(1);
            end else begin
              state_q  <= S_IDLE;
              idx_q    <= '0;
              txrx_q   <= 1'b1;
              listen_q <= 1'b0;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
            end
          end
          default: begin
            state_q  <= S_IDLE;
            hstate_q <= HB_OFF;
            txrx_q   <= 1'b1;
            busy_q   <= 1'b0;
            listen_q <= 1'b0;
            idx_q    <= '0;
          end
        endcase
      end
    end
  end

  assign hstate     = hstate_q;
  assign txrx       = txrx_q;
  assign busy       = busy_q;
  assign listen     = listen_q;
  assign listen_idx = idx_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_ping_sequencer.sv
// Directed bench for ping_sequencer: cycle-by-cycle output checks of complete
// pings, rejected starts, abort, held start and reset during a ping.
module tb_ping_sequencer;

  localparam logic [1:0] OFF = 2'b00;
  localparam logic [1:0] POS = 2'b01;
  localparam logic [1:0] NEG = 2'b10;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [15:0] half_period, dead_time;
  logic [7:0]  n_cycles;
  logic [23:0] listen_len;
  logic [1:0]  hstate;
  logic        txrx, busy, listen, done, err;
  logic [23:0] listen_idx;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ping_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .half_period(half_period), .n_cycles(n_cycles),
    .dead_time(dead_time), .listen_len(listen_len),
    .hstate(hstate), .txrx(txrx), .busy(busy), .listen(listen),
    .listen_idx(listen_idx), .done(done), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [1:0] hs, input logic tx,
                            input logic bz, input logic li, input logic [23:0] idx,
                            input logic dn, input logic er);
    check({tag, " hstate"}, 32'(hstate), 32'(hs));
    check({tag, " txrx"}, 32'(txrx), 32'(tx));
    check({tag, " busy"}, 32'(busy), 32'(bz));
    check({tag, " listen"}, 32'(listen), 32'(li));
    check({tag, " listen_idx"}, 32'(listen_idx), 32'(idx));
    check({tag, " done"}, 32'(done), 32'(dn));
    check({tag, " err"}, 32'(err), 32'(er));
  endtask

  // Start a ping at cycle 0 and check every cycle through the done cycle.
  // With hold, start stays high and the cycle after done must begin a new burst.
  task automatic run_ping(input string tag, input int hp, input int nc, input int dt,
                          input int ll, input bit hold);
    int b, total, last;
    b     = 2 * hp * nc;
    total = b + dt + ll;
    last  = hold ? total + 2 : total + 1;
    half_period = 16'(hp);
    n_cycles    = 8'(nc);
    dead_time   = 16'(dt);
    listen_len  = 24'(ll);
    start = 1'b1;
    step();
    if (!hold) start = 1'b0;
    // Config changes after the start cycle must be ignored
    half_period = 16'd9;
    n_cycles    = 8'd5;
    dead_time   = 16'd7;
    listen_len  = 24'd11;
    for (int c = 1; c <= last; c++) begin
      string t;
      t = $sformatf("%s c%0d", tag, c);
      if (c <= b)
        check_outs(t, (((c - 1) / hp) % 2 == 0) ? POS : NEG, 1'b1, 1'b1, 1'b0, 24'd0, 1'b0, 1'b0);
      else if (c <= b + dt)
        check_outs(t, OFF, 1'b1, 1'b1, 1'b0, 24'd0, 1'b0, 1'b0);
      else if (c <= total)
        check_outs(t, OFF, 1'b0, 1'b1, 1'b1, 24'(c - b - dt - 1), 1'b0, 1'b0);
      else if (c == total + 1)
        check_outs(t, OFF, 1'b1, 1'b0, 1'b0, 24'd0, 1'b1, 1'b0);
      else
        check_outs(t, POS, 1'b1, 1'b1, 1'b0, 24'd0, 1'b0, 1'b0);
      step();
    end
    start = 1'b0;
    if (hold) begin
      abort = 1'b1;
      step();
      abort = 1'b0;
      step();
    end
  endtask

  // Present an invalid config and expect a lone err pulse with outputs idle
  task automatic reject(input string tag, input int hp, input int nc);
    half_period = 16'(hp);
    n_cycles    = 8'(nc);
    dead_time   = 16'd1;
    listen_len  = 24'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    check_outs({tag, " pulse"}, OFF, 1'b1, 1'b0, 1'b0, 24'd0, 1'b0, 1'b1);
    step();
    check_outs({tag, " after"}, OFF, 1'b1, 1'b0, 1'b0, 24'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    half_period = '0; n_cycles = '0; dead_time = '0; listen_len = '0;
    step();
    step();
    check_outs("reset", OFF, 1'b1, 1'b0, 1'b0, 24'd0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    check_outs("idle", OFF, 1'b1, 1'b0, 1'b0, 24'd0, 1'b0, 1'b0);

    // Full ping with dead time and listen window
    run_ping("t1", 4, 2, 3, 5, 1'b0);

    // Rejected starts
    reject("t2 nc0", 4, 0);
    reject("t2 hp1", 1, 2);
    reject("t2 hp0", 0, 1);

    // abort and start together in IDLE: nothing happens
    half_period = 16'd4; n_cycles = 8'd1; dead_time = 16'd0; listen_len = 24'd0;
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check_outs("abort+start", OFF, 1'b1, 1'b0, 1'b0, 24'd0, 1'b0, 1'b0);
    step();
    check_outs("abort+start2", OFF, 1'b1, 1'b0, 1'b0, 24'd0, 1'b0, 1'b0);

    // Abort during the second NEG half (cycles 13-16 for hp=4)
    half_period = 16'd4; n_cycles = 8'd3; dead_time = 16'd2; listen_len = 24'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 2; c <= 14; c++) step();
    check_outs("t3 c14", NEG, 1'b1, 1'b1, 1'b0, 24'd0, 1'b0, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_outs("t3 c15", OFF, 1'b1, 1'b0, 1'b0, 24'd0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      check_outs($sformatf("t3 post%0d", k), OFF, 1'b1, 1'b0, 1'b0, 24'd0, 1'b0, 1'b0);
    end

    // No dead time, no listen
    run_ping("t4", 2, 1, 0, 0, 1'b0);

    // start held high: one ping, then the next starts right after done
    run_ping("t5", 2, 1, 0, 1, 1'b1);

    // Dead time but no listen window
    run_ping("t7", 2, 2, 2, 0, 1'b0);

    // Reset during LISTEN (hp2 nc1 dt1 ll5: listen occupies cycles 6-10)
    half_period = 16'd2; n_cycles = 8'd1; dead_time = 16'd1; listen_len = 24'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 2; c <= 7; c++) step();
    check_outs("t6 c7", OFF, 1'b0, 1'b1, 1'b1, 24'd1, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_outs("t6 rst", OFF, 1'b1, 1'b0, 1'b0, 24'd0, 1'b0, 1'b0);
    step();
    check_outs("t6 idle", OFF, 1'b1, 1'b0, 1'b0, 24'd0, 1'b0, 1'b0);
    run_ping("t6 ping", 3, 2, 0, 2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
